// File: rtl/tc_sram_tiled_if.sv
// Request/response bus of the tiled IHP13 SRAM wrapper.
// The master drives requests; the slave (memory) returns grant and read data.
interface tc_sram_tiled_if #(
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned DataWidth = 128,
  parameter int unsigned BeWidth   = 16
) ();
  logic                 req_i;
  logic                 we_i;
  logic [AddrWidth-1:0] addr_i;
  logic [DataWidth-1:0] wdata_i;
  logic [BeWidth-1:0]   be_i;
  logic                 gnt_o;
  logic                 rvalid_o;
  logic [DataWidth-1:0] rdata_o;
  logic                 rerr_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i, be_i,
    input  gnt_o, rvalid_o, rdata_o, rerr_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, be_i,
    output gnt_o, rvalid_o, rdata_o, rerr_o
  );
endinterface

// File: rtl/tc_sram_tiled.sv
// NumWords x DataWidth single-port SRAM tiled from 64-bit IHP13 cuts, with
// configurable read latency, req/gnt handshake, power-on scrub and range check.
module tc_sram_tiled #(
  parameter int unsigned NumWords   = 1024,
  parameter int unsigned DataWidth  = 128,
  parameter int unsigned ByteWidth  = 8,
  parameter int unsigned MacroWords = 256,
  parameter int unsigned Latency    = 1,
  parameter bit          InitZero   = 1'b1,
  localparam int unsigned NumBanks  = NumWords / MacroWords,
  localparam int unsigned NumCols   = DataWidth / 64,
  localparam int unsigned AddrWidth = $clog2(NumWords),
  localparam int unsigned RowWidth  = $clog2(MacroWords),
  localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth,
  localparam int unsigned BankWidth = (NumBanks > 1) ? $clog2(NumBanks) : 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  tc_sram_tiled_if.slave bus,
  output logic           init_done_o
);

  typedef enum logic {INIT, READY} state_e;

  state_e                state_q, state_d;
  logic [RowWidth-1:0]   row_q, row_d;

  logic                  gnt;
  logic                  oor;
  logic [BankWidth-1:0]  bank;
  logic [DataWidth-1:0]  bm_in;

  logic [NumBanks-1:0]   men;
  logic                  cut_wen;
  logic                  cut_ren;
  logic [RowWidth-1:0]   cut_row;
  logic [DataWidth-1:0]  cut_din;
  logic [DataWidth-1:0]  cut_bm;
  logic [NumBanks-1:0][DataWidth-1:0] bank_dout;

  logic                  s1_v, s1_e;
  logic [BankWidth-1:0]  s1_bank;
  logic [DataWidth-1:0]  s1_d;
  logic                  fin_v, fin_e;
  logic [DataWidth-1:0]  fin_d;
  logic [DataWidth-1:0]  hold_d;
  logic                  hold_e;

  // Init FSM: scrub every row of all banks in parallel, then stay READY.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= InitZero ? INIT : READY;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    if (state_q == INIT) begin
      row_d = row_q + 1'b1;
      if (row_q == RowWidth'(MacroWords - 1)) begin
        state_d = READY;
        row_d   = '0;
      end
    end
  end

  assign init_done_o = (state_q == READY);
  assign gnt         = bus.req_i & init_done_o;
  assign bus.gnt_o   = gnt;
  assign bank        = BankWidth'(bus.addr_i >> RowWidth);
  assign oor         = 32'(bus.addr_i) >= NumWords;

  always_comb begin
    bm_in = '0;
    for (int unsigned i = 0; i < DataWidth; i++) begin
      bm_in[i] = bus.be_i[i / ByteWidth];
    end
  end

  always_comb begin
    men     = '0;
    cut_wen = 1'b0;
    cut_ren = 1'b0;
    cut_row = bus.addr_i[RowWidth-1:0];
    cut_din = bus.wdata_i;
    cut_bm  = bm_in;
    if (state_q == INIT) begin
      men     = '1;
      cut_wen = 1'b1;
      cut_row = row_q;
      cut_din = '0;
      cut_bm  = '1;
    end else if (gnt && !oor) begin
      men[bank] = 1'b1;
      cut_wen   = bus.we_i;
      cut_ren   = ~bus.we_i;
    end
  end

  // Behavioural equivalent of one RM_IHPSG13_1P_<MacroWords>x64 cut per
  // bank/column; BIST inputs and A_DLY are tied low so only the functional port exists.
  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    for (genvar c = 0; c < NumCols; c++) begin : g_col
      logic [63:0] mem_q [MacroWords];
      logic [63:0] dout_q;

      always_ff @(posedge clk_i) begin
        if (men[b]) begin
          if (cut_wen) begin
            mem_q[cut_row] <= (mem_q[cut_row] & ~cut_bm[64*c +: 64])
                            | (cut_din[64*c +: 64] & cut_bm[64*c +: 64]);
          end
          if (cut_ren) begin
            dout_q <= mem_q[cut_row];
          end
        end
      end

      assign bank_dout[b][64*c +: 64] = dout_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_v    <= 1'b0;
      s1_e    <= 1'b0;
      s1_bank <= '0;
    end else begin
      s1_v <= gnt & ~bus.we_i;
      if (gnt && !bus.we_i) begin
        s1_e    <= oor;
        s1_bank <= bank;
      end
    end
  end

  assign s1_d = s1_e ? '0 : bank_dout[s1_bank];

  if (Latency == 1) begin : g_lat1
    assign fin_v = s1_v;
    assign fin_e = s1_e;
    assign fin_d = s1_d;
  end else begin : g_pipe
    localparam int unsigned Depth = Latency - 1;
    logic [Depth-1:0]     v_q;
    logic [Depth-1:0]     e_q;
    logic [DataWidth-1:0] d_q [Depth];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        v_q <= '0;
        e_q <= '0;
        for (int unsigned i = 0; i < Depth; i++) d_q[i] <= '0;
      end else begin
        v_q[0] <= s1_v;
        e_q[0] <= s1_e;
        d_q[0] <= s1_d;
        for (int unsigned i = 1; i < Depth; i++) begin
          v_q[i] <= v_q[i-1];
          e_q[i] <= e_q[i-1];
          d_q[i] <= d_q[i-1];
        end
      end
    end

    assign fin_v = v_q[Depth-1];
    assign fin_e = e_q[Depth-1];
    assign fin_d = d_q[Depth-1];
  end

  // Pipeline data moves every cycle; this register keeps the last completed read visible.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_d <= '0;
      hold_e <= 1'b0;
    end else if (fin_v) begin
      hold_d <= fin_d;
      hold_e <= fin_e;
    end
  end

  assign bus.rvalid_o = fin_v;
  assign bus.rdata_o  = fin_v ? fin_d : hold_d;
  assign bus.rerr_o   = fin_v ? fin_e : hold_e;

endmodule

// File: tb/tb_tc_sram_tiled.sv
// Directed + random bench for tc_sram_tiled: a 3-bank/latency-3 instance and a
// 4-bank/latency-2 instance checked against a word-array reference model.
module tb_tc_sram_tiled;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 128;
  localparam int unsigned BW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a, rst_b, req_a, req_b, we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [BW-1:0] be;
  logic          done_a, done_b;

  tc_sram_tiled_if #(.AddrWidth(AW), .DataWidth(DW), .BeWidth(BW)) bus_a ();
  tc_sram_tiled_if #(.AddrWidth(AW), .DataWidth(DW), .BeWidth(BW)) bus_b ();

  assign bus_a.req_i = req_a;  assign bus_b.req_i = req_b;
  assign bus_a.we_i  = we;     assign bus_b.we_i  = we;
  assign bus_a.addr_i = addr;  assign bus_b.addr_i = addr;
  assign bus_a.wdata_i = wdata; assign bus_b.wdata_i = wdata;
  assign bus_a.be_i  = be;     assign bus_b.be_i  = be;

  tc_sram_tiled #(.NumWords(768), .DataWidth(128), .ByteWidth(8), .MacroWords(256),
                  .Latency(3), .InitZero(1'b1))
    u_a (.clk_i(clk), .rst_i(rst_a), .bus(bus_a), .init_done_o(done_a));

  tc_sram_tiled #(.NumWords(1024), .DataWidth(128), .ByteWidth(8), .MacroWords(256),
                  .Latency(2), .InitZero(1'b1))
    u_b (.clk_i(clk), .rst_i(rst_b), .bus(bus_b), .init_done_o(done_b));

  // Reference model: one word per address, all zero after a scrub.
  logic [DW-1:0] mem_a [768];
  logic [DW-1:0] mem_b [1024];
  logic [DW-1:0] last_d [2];
  logic          last_e [2];

  int total, bad;

  int            n;
  logic          op_we   [40];
  logic [AW-1:0] op_addr [40];
  logic [DW-1:0] op_wd   [40];
  logic [BW-1:0] op_be   [40];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic obs_gnt(input int inst);
    return (inst != 0) ? bus_b.gnt_o : bus_a.gnt_o;
  endfunction
  function automatic logic obs_v(input int inst);
    return (inst != 0) ? bus_b.rvalid_o : bus_a.rvalid_o;
  endfunction
  function automatic logic [DW-1:0] obs_d(input int inst);
    return (inst != 0) ? bus_b.rdata_o : bus_a.rdata_o;
  endfunction
  function automatic logic obs_e(input int inst);
    return (inst != 0) ? bus_b.rerr_o : bus_a.rerr_o;
  endfunction
  function automatic logic obs_done(input int inst);
    return (inst != 0) ? done_b : done_a;
  endfunction

  function automatic logic [DW-1:0] byte_mask(input logic [BW-1:0] b);
    logic [DW-1:0] m;
    for (int i = 0; i < BW; i++) m[i*8 +: 8] = {8{b[i]}};
    return m;
  endfunction

  task automatic set_req(input int inst, input logic v);
    if (inst != 0) req_b = v; else req_a = v;
  endtask

  task automatic zero_model(input int inst);
    if (inst != 0) for (int i = 0; i < 1024; i++) mem_b[i] = '0;
    else           for (int i = 0; i < 768; i++)  mem_a[i] = '0;
    last_d[inst] = '0;
    last_e[inst] = 1'b0;
  endtask

  task automatic add_op(input int w, input int a, input logic [DW-1:0] d, input logic [BW-1:0] b);
    op_we[n]   = (w != 0);
    op_addr[n] = AW'(a);
    op_wd[n]   = d;
    op_be[n]   = b;
    n++;
  endtask

  // Counts edges from reset release to init_done (bounded); expects MacroWords=256.
  task automatic init_check(input int inst, input string tag);
    int   edges;
    logic saw_gnt;
    edges = 0; saw_gnt = 1'b0;
    we = 1'b0; addr = '0;
    set_req(inst, 1'b1);
    #1;
    while (!obs_done(inst) && edges < 1000) begin
      if (obs_gnt(inst)) saw_gnt = 1'b1;
      @(posedge clk); #1;
      edges++;
    end
    set_req(inst, 1'b0);
    chk({tag, "_len"}, DW'(edges), DW'(256));
    chk({tag, "_gnt_in_init"}, DW'(saw_gnt), '0);
    zero_model(inst);
  endtask

  // Issues the queued ops one per cycle; checks gnt, rvalid timing, data, err and output hold.
  task automatic run_stream(input int inst);
    int            lat, words;
    logic          ev [48];
    logic [DW-1:0] ed [48];
    logic          ee [48];
    lat   = (inst != 0) ? 2 : 3;
    words = (inst != 0) ? 1024 : 768;
    for (int i = 0; i < 48; i++) begin ev[i] = 1'b0; ed[i] = '0; ee[i] = 1'b0; end
    for (int cyc = 0; cyc < n + lat + 1; cyc++) begin
      if (cyc < n) begin
        we = op_we[cyc]; addr = op_addr[cyc]; wdata = op_wd[cyc]; be = op_be[cyc];
        set_req(inst, 1'b1);
        if (!op_we[cyc]) begin
          ev[cyc+lat] = 1'b1;
          if (int'(op_addr[cyc]) >= words) begin
            ed[cyc+lat] = '0; ee[cyc+lat] = 1'b1;
          end else begin
            ed[cyc+lat] = (inst != 0) ? mem_b[op_addr[cyc]] : mem_a[op_addr[cyc]];
            ee[cyc+lat] = 1'b0;
          end
        end else if (int'(op_addr[cyc]) < words) begin
          if (inst != 0)
            mem_b[op_addr[cyc]] = (mem_b[op_addr[cyc]] & ~byte_mask(op_be[cyc]))
                                | (op_wd[cyc] & byte_mask(op_be[cyc]));
          else
            mem_a[op_addr[cyc]] = (mem_a[op_addr[cyc]] & ~byte_mask(op_be[cyc]))
                                | (op_wd[cyc] & byte_mask(op_be[cyc]));
        end
      end else begin
        set_req(inst, 1'b0);
      end
      #1;
      if (cyc < n) chk($sformatf("gnt%0d_c%0d", inst, cyc), DW'(obs_gnt(inst)), DW'(1));
      chk($sformatf("rvalid%0d_c%0d", inst, cyc), DW'(obs_v(inst)), DW'(ev[cyc]));
      if (ev[cyc]) begin
        last_d[inst] = ed[cyc];
        last_e[inst] = ee[cyc];
      end
      chk($sformatf("rdata%0d_c%0d", inst, cyc), obs_d(inst), last_d[inst]);
      chk($sformatf("rerr%0d_c%0d", inst, cyc), DW'(obs_e(inst)), DW'(last_e[inst]));
      @(posedge clk); #1;
    end
    set_req(inst, 1'b0);
    n = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0; n = 0;
    rst_a = 1'b1; rst_b = 1'b1;
    req_a = 1'b1; req_b = 1'b1;
    we = 1'b0; addr = '0; wdata = '0; be = '0;
    zero_model(0); zero_model(1);
    #2;
    chk("rst_gnt_a",   DW'(bus_a.gnt_o),    '0);
    chk("rst_rvalid_a", DW'(bus_a.rvalid_o), '0);
    chk("rst_rdata_a", bus_a.rdata_o,        '0);
    chk("rst_rerr_a",  DW'(bus_a.rerr_o),   '0);
    chk("rst_done_a",  DW'(done_a),         '0);
    chk("rst_gnt_b",   DW'(bus_b.gnt_o),    '0);
    chk("rst_rvalid_b", DW'(bus_b.rvalid_o), '0);
    chk("rst_rdata_b", bus_b.rdata_o,        '0);
    chk("rst_done_b",  DW'(done_b),         '0);
    req_a = 1'b0; req_b = 1'b0;

    @(posedge clk); #1;
    rst_a = 1'b0;
    init_check(0, "init_a");

    // Scrubbed reads, bank interleave, out-of-range write/read and aliasing rows.
    add_op(0, 0, '0, '0);
    add_op(0, 300, '0, '0);
    add_op(0, 511, '0, '0);
    add_op(0, 767, '0, '0);
    add_op(1, 10, 128'hA, '1);
    add_op(1, 266, 128'hB, '1);
    add_op(0, 10, '0, '0);
    add_op(0, 266, '0, '0);
    add_op(1, 800, {4{32'hDEADBEEF}}, '1);
    add_op(0, 800, '0, '0);
    add_op(0, 32, '0, '0);
    add_op(0, 288, '0, '0);
    add_op(0, 544, '0, '0);
    run_stream(0);

    for (int k = 0; k < 30; k++)
      add_op($urandom_range(1, 0), $urandom_range(1023, 0),
             {$urandom(), $urandom(), $urandom(), $urandom()}, BW'($urandom()));
    run_stream(0);

    // Reset in the middle of the scrub restarts it from row 0.
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    repeat (100) begin @(posedge clk); #1; end
    chk("midinit_busy_a", DW'(done_a), '0);
    rst_a = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst_a = 1'b0;
    init_check(0, "midinit_a");
    for (int k = 0; k < 6; k++) add_op(0, $urandom_range(767, 0), '0, '0);
    run_stream(0);

    rst_b = 1'b0;
    init_check(1, "init_b");

    add_op(1, 5, 128'h00112233_44556677_8899AABB_CCDDEEFF, '1);
    add_op(1, 5, '0, 16'h00F0);
    add_op(0, 5, '0, '0);
    run_stream(1);

    // Reset one cycle after a granted read: the read must never complete.
    we = 1'b0; addr = AW'(5); req_b = 1'b1;
    #1;
    chk("rdrst_gnt_b", DW'(bus_b.gnt_o), DW'(1));
    @(posedge clk); #1;
    req_b = 1'b0;
    rst_b = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rdrst_rvalid_b%0d", k), DW'(bus_b.rvalid_o), '0);
      chk($sformatf("rdrst_rdata_b%0d", k), bus_b.rdata_o, '0);
      @(posedge clk); #1;
    end
    rst_b = 1'b0;
    init_check(1, "rdrst_b");

    for (int k = 0; k < 30; k++)
      add_op($urandom_range(1, 0), $urandom_range(1023, 0),
             {$urandom(), $urandom(), $urandom(), $urandom()},
             ($urandom_range(3, 0) == 0) ? '1 : BW'($urandom()));
    run_stream(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tc_sram_tiled.md
# tc_sram_tiled

Single-port SRAM wrapper for the IHP13 technology that builds arbitrary `NumWords x DataWidth` memories by tiling `RM_IHPSG13_1P_<MacroWords>x64_c2_bm_bist` cuts in depth (banks) and width (columns). It sits wherever the core instantiates scratchpad or cache memories and replaces ad-hoc per-size cut selection. Beyond the plain cut wrapper it adds:

- a configurable read-pipeline latency;
- a request/grant handshake with read-valid tagging;
- an optional power-on zeroing sequence;
- out-of-range access detection.

## Interface
- `NumWords`, default 1024: total words; must equal `NumBanks*MacroWords`, with `NumBanks` in 1..8.
- `DataWidth`, default 128: word width; a multiple of 64, at most 256 (1..4 columns).
- `ByteWidth`, default 8: bits per byte-enable.
- `MacroWords`, default 256: cut depth, one of 256, 512, 1024 or 2048; selects the instantiated cut.
- `Latency`, default 1: read latency in cycles, 1..3.
- `InitZero`, default 1'b1: when set, zero all rows after reset.
- Derived (do not override): `NumBanks = NumWords/MacroWords`, `NumCols = DataWidth/64`, `AddrWidth = $clog2(NumWords)`, `RowWidth = $clog2(MacroWords)`, `BeWidth = ceil(DataWidth/ByteWidth)`.
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `req_i`, in, 1: access request.
- `we_i`, in, 1: 1 = write, 0 = read.
- `addr_i`, in, AddrWidth: word address.
- `wdata_i`, in, DataWidth: write data.
- `be_i`, in, BeWidth: byte enables.
- `gnt_o`, out, 1: request accepted this cycle.
- `rvalid_o`, out, 1: read data valid.
- `rdata_o`, out, DataWidth: read data.
- `rerr_o`, out, 1: the read completing on `rvalid_o` was out of range.
- `init_done_o`, out, 1: memory ready for accesses.

## Operation
- Address split:
  - `row = addr_i[RowWidth-1:0]`.
  - `bank = addr_i >> RowWidth`.
  - Out of range when `addr_i >= NumWords`; this is only possible for non-power-of-2 `NumBanks`.
- Bit mask: `bm[b] = be_i[b/ByteWidth]`, replicated per column slice `[64c+63:64c]`.
- Cut control on a granted access:
  - Only the addressed bank gets `A_MEN=1`.
  - `A_WEN=we_i`, `A_REN=~we_i`.
  - `A_ADDR` gets `row`; `A_DIN` and `A_BM` get the column slices.
  - All BIST inputs and `A_DLY` are tied to 0.
- Handshake: `gnt_o = req_i & init_done_o`, combinational. An ungranted request has no effect, and the requester must hold it until granted.
- Out-of-range write: granted, but no bank enabled and no state changed.
- Out-of-range read: granted, `rvalid_o` is raised with `rerr_o=1` and `rdata_o` is all zeros.
- Read path:
  - On a granted read, the bank index and out-of-range flag are registered.
  - The bank mux selects cut `A_DOUT` using the registered bank.
  - Stage 1 is the cut itself. `Latency-1` further register stages follow the mux, each carrying data, valid and err.
- Output hold: `rdata_o` and `rerr_o` keep their last valid value until the next `rvalid_o`. Writes never raise `rvalid_o`.
- Init FSM, states INIT → READY:
  - Reset enters INIT if `InitZero=1`, otherwise READY.
  - In INIT, a row counter steps 0..MacroWords-1. Every cycle, all banks are driven with `A_MEN=1`, `A_WEN=1`, `A_BM` all ones, `A_DIN=0`, and the same row, so all banks are scrubbed in parallel.
  - When the counter reaches MacroWords-1, the next state is READY.
  - READY is terminal until reset.
  - `init_done_o = (state==READY)`.
- Reset mid-INIT or mid-read: all pipeline valids are cleared, the FSM restarts from row 0, and in-flight reads are dropped with no `rvalid_o`.

## Timing
- Reset values:
  - `gnt_o=0` while INIT.
  - `rvalid_o=0`, `rerr_o=0`, `rdata_o=0`.
  - `init_done_o=~InitZero`, row counter 0.
- Init duration: reset released before edge 0 ⇒ `init_done_o` rises after exactly MacroWords rising edges. The first grant is possible in that cycle.
- Read latency: a read granted in cycle t ⇒ `rvalid_o=1` in cycle t+Latency, for one cycle per read.
- Throughput: fully pipelined, one access per cycle. Back-to-back reads to different banks return in order, with no bubble.
- Read-after-write to the same address in consecutive cycles returns the new data.
- A simultaneous read completion and new request is legal. Read valid output never stalls; there is no backpressure.

## Test plan
- Scrub, NumWords=512, MacroWords=256, InitZero=1: after reset, `init_done_o` stays 0 for 256 cycles and `gnt_o=0` despite `req_i=1`. Then read addr 0, 300 and 511 ⇒ each returns 0.
- Byte enables, DataWidth=128: write `0x00112233_44556677_8899AABB_CCDDEEFF` to addr 5 with be all ones, then write zero with `be=16'h00F0`, then read ⇒ `0x00112233_44556677_0000_0000_CCDDEEFF`, with `rvalid_o` exactly Latency cycles after grant.
- Bank interleave, Latency=3: write `0xA` to addr 10 (bank 0) and `0xB` to addr 266 (bank 1). Read both back-to-back ⇒ `rvalid_o` high in cycles t+3 and t+4 with `0xA` then `0xB`.
- Out of range, NumWords=768, MacroWords=256: write to 800, then read 800 ⇒ `rerr_o=1`, `rdata_o=0`. Read 32 ⇒ `rerr_o=0`, and no word in 0..767 is modified.
- Reset mid-init: assert `rst_i` at scrub row 100 for 2 cycles ⇒ `init_done_o` rises MacroWords cycles after release.
- Reset mid-read: assert `rst_i` one cycle after a granted read with Latency=2 ⇒ no `rvalid_o`, and `rdata_o=0`.
